cpu_multicycle: RTL and testbench

Parametrised multi-cycle RISC-V integer core that succeeds the single-cycle lab CPU. Each instruction is fetched over a req/ack instruction-memory handshake and sequenced by a five-phase FSM, so wait-stated memories are tolerated. The core adds `beq`, `xor`, `srai` and an illegal-instruction halt, with a debug register-read port for verification.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_regfile.sv | 42 ++++
 rtl/cpu_multicycle.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the multi-cycle RISC-V integer core.
package cpu_pkg;

  localparam int OPC_W   = 7;
  localparam int REG_W   = 5;
  localparam int F3_W    = 3;
  localparam int F7_W    = 7;
  localparam int IMM_I_W = 12;
  localparam int IMM_B_W = 13;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL = 3'b001;
  localparam logic [F3_W-1:0] F3_XOR = 3'b100;
  localparam logic [F3_W-1:0] F3_SR  = 3'b101;
  localparam logic [F3_W-1:0] F3_OR  = 3'b110;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;
  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;
  localparam logic [F7_W-1:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, WB, HALT} state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
  } alu_op_t;

endpackage

// File: rtl/cpu_regfile.sv
// Integer register file: two combinational read ports, one write port, debug read.
// x0 is never written, so it always reads zero; indices >= NUM_REGS read zero.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] raddr_a,
  output logic [XLEN-1:0]  rdata_a,
  input  logic [REG_W-1:0] raddr_b,
  output logic [XLEN-1:0]  rdata_b,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [REG_W-1:0] dbg_sel,
  output logic [XLEN-1:0]  dbg_data
);

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];

  function automatic logic in_range(logic [REG_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  assign rdata_a  = in_range(raddr_a) ? regs[raddr_a[AW-1:0]] : '0;
  assign rdata_b  = in_range(raddr_b) ? regs[raddr_b[AW-1:0]] : '0;
  assign dbg_data = in_range(dbg_sel) ? regs[dbg_sel[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0 && in_range(waddr)) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32/64 integer core with req/ack instruction fetch and illegal-op halt.
// Build option: define CPU_MUL_EN to execute mul; otherwise mul halts as illegal.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             retire_o,
  output logic             halt_o,
  input  logic [REG_W-1:0] dbg_sel_i,
  output logic [XLEN-1:0]  dbg_data_o
);

  // state  | meaning
  // BOOT   | one idle cycle after reset release before the first fetch
  // FETCH  | request held with PC on the bus until ack, IR latched
  // DECODE | legality check, operand read, immediate sign-extension
  // EXEC   | ALU result and beq comparison latched
  // WB     | rd written, PC advanced, retire pulse
  // HALT   | illegal instruction seen; left only through reset

  localparam int SHW = $clog2(XLEN);

  state_t          state;
  logic            boot_done;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc, op_a, op_b, imm, result;
  alu_op_t         op;
  logic [REG_W-1:0] rd;
  logic            wb_en, is_beq, taken;

  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] rd_f, rs1_f, rs2_f;
  logic [F3_W-1:0]  f3;
  logic [F7_W-1:0]  f7;
  logic [XLEN-1:0]  imm_i, imm_b, rs1_data, rs2_data, alu_out;

  assign opcode = ir[0 +: OPC_W];
  assign rd_f   = ir[7 +: REG_W];
  assign f3     = ir[12 +: F3_W];
  assign rs1_f  = ir[15 +: REG_W];
  assign rs2_f  = ir[20 +: REG_W];
  assign f7     = ir[25 +: F7_W];
  assign imm_i  = {{(XLEN-IMM_I_W){ir[31]}}, ir[31:20]};
  assign imm_b  = {{(XLEN-IMM_B_W){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  assign imem_addr_o = pc;

  function automatic logic reg_ok(logic [REG_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  logic    dec_legal, dec_use_imm, dec_wb, dec_beq, dec_rs2, dec_rd;
  alu_op_t dec_op;

  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_wb      = 1'b0;
    dec_beq     = 1'b0;
    dec_rs2     = 1'b0;
    dec_rd      = 1'b0;
    dec_op      = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec_wb  = 1'b1;
        dec_rs2 = 1'b1;
        dec_rd  = 1'b1;
        if (f7 == F7_BASE) begin
          dec_legal = 1'b1;
          case (f3)
            F3_ADD:  dec_op = ALU_ADD;
            F3_SLL:  dec_op = ALU_SLL;
            F3_XOR:  dec_op = ALU_XOR;
            F3_OR:   dec_op = ALU_OR;
            F3_AND:  dec_op = ALU_AND;
            default: dec_legal = 1'b0;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
`ifdef CPU_MUL_EN
        end else if (f7 == F7_MUL && f3 == F3_ADD) begin
          dec_legal = 1'b1;
          dec_op    = ALU_MUL;
`endif
        end
      end
      OPC_OP_IMM: begin
        dec_wb      = 1'b1;
        dec_rd      = 1'b1;
        dec_use_imm = 1'b1;
        if (f3 == F3_ADD) begin
          dec_legal = 1'b1;
          dec_op    = ALU_ADD;
        end else if (f3 == F3_SR && f7[6:1] == F7_ALT[6:1] && (XLEN == 64 || !f7[0])) begin
          // shamt lives in the low SHW bits of the I-immediate
          dec_legal = 1'b1;
          dec_op    = ALU_SRA;
        end
      end
      OPC_BRANCH: begin
        dec_rs2 = 1'b1;
        dec_beq = 1'b1;
        dec_legal = (f3 == F3_BEQ);
      end
      default: ;
    endcase
    if (!reg_ok(rs1_f) || (dec_rs2 && !reg_ok(rs2_f)) || (dec_rd && !reg_ok(rd_f)))
      dec_legal = 1'b0;
  end

  always_comb begin
    alu_out = '0;
    case (op)
      ALU_ADD: alu_out = op_a + op_b;
      ALU_SUB: alu_out = op_a - op_b;
      ALU_AND: alu_out = op_a & op_b;
      ALU_OR:  alu_out = op_a | op_b;
      ALU_XOR: alu_out = op_a ^ op_b;
      ALU_SLL: alu_out = op_a << op_b[SHW-1:0];
      ALU_SRA: alu_out = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
`ifdef CPU_MUL_EN
      ALU_MUL: alu_out = op_a * op_b;
`endif
      default: alu_out = op_a + op_b;
    endcase
  end

  cpu_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .raddr_a  (rs1_f),
    .rdata_a  (rs1_data),
    .raddr_b  (rs2_f),
    .rdata_b  (rs2_data),
    .we       (state == WB && wb_en),
    .waddr    (rd),
    .wdata    (result),
    .dbg_sel  (dbg_sel_i),
    .dbg_data (dbg_data_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= BOOT;
      boot_done  <= 1'b0;
      imem_req_o <= 1'b0;
      retire_o   <= 1'b0;
      halt_o     <= 1'b0;
      pc         <= PC_RESET;
      ir         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      imm        <= '0;
      result     <= '0;
      op         <= ALU_ADD;
      rd         <= '0;
      wb_en      <= 1'b0;
      is_beq     <= 1'b0;
      taken      <= 1'b0;
    end else begin
      retire_o <= 1'b0;
      case (state)
        BOOT: begin
          if (boot_done) begin
            state      <= FETCH;
            imem_req_o <= 1'b1;
          end else begin
            boot_done <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack_i) begin
            ir         <= imem_rdata_i;
            imem_req_o <= 1'b0;
            state      <= DECODE;
          end
        end
        DECODE: begin
          if (!dec_legal) begin
            state  <= HALT;
            halt_o <= 1'b1;
          end else begin
            op_a   <= rs1_data;
            op_b   <= dec_use_imm ? imm_i : rs2_data;
            imm    <= dec_beq ? imm_b : imm_i;
            op     <= dec_op;
            rd     <= rd_f;
            wb_en  <= dec_wb;
            is_beq <= dec_beq;
            state  <= EXEC;
          end
        end
        EXEC: begin
          result   <= alu_out;
          taken    <= (op_a == op_b);
          retire_o <= 1'b1;
          state    <= WB;
        end
        WB: begin
          pc         <= (is_beq && taken) ? pc + imm : pc + XLEN'(4);
          imem_req_o <= 1'b1;
          state      <= FETCH;
        end
        HALT: ;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: table of small programs plus timing/halt/reset sequences.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, ack, retire, halt;
  logic [31:0] addr, rdata, dbg_data;
  logic [4:0]  dbg_sel;
  logic        req16, ack16, retire16, halt16;
  logic [31:0] addr16, rdata16, dbg_data16;

  always #5 clk = ~clk;

  cpu_multicycle #(.XLEN(32), .NUM_REGS(32), .PC_RESET(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_n), .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
    .imem_rdata_i(rdata), .retire_o(retire), .halt_o(halt), .dbg_sel_i(dbg_sel),
    .dbg_data_o(dbg_data)
  );

  cpu_multicycle #(.XLEN(32), .NUM_REGS(16), .PC_RESET(32'h0)) dut16 (
    .clk_i(clk), .rst_i(rst_n), .imem_req_o(req16), .imem_addr_o(addr16), .imem_ack_i(ack16),
    .imem_rdata_i(rdata16), .retire_o(retire16), .halt_o(halt16), .dbg_sel_i(dbg_sel),
    .dbg_data_o(dbg_data16)
  );

  logic [31:0] mem [64];
  int          delay = 0;
  int          wcnt = 0;

  // Instruction memory: ack after `delay` wait cycles, driven between clock edges.
  always @(negedge clk) begin
    ack = 1'b0;
    if (req) begin
      if (wcnt >= delay) begin
        ack   = 1'b1;
        rdata = mem[addr[7:2]];
        wcnt  = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) ack16 = req16;

  int          cyc = 0, retire_cnt = 0, retire16_cnt = 0, addr_glitch = 0;
  int          retire_cyc[$];
  logic [31:0] fetch_addr[$];
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (retire) begin
      retire_cnt++;
      retire_cyc.push_back(cyc);
    end
    if (retire16) retire16_cnt++;
    if (req && !prev_req) fetch_addr.push_back(addr);
    if (req && prev_req && addr != prev_addr) addr_glitch++;
    prev_req  = req;
    prev_addr = addr;
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) mem[k] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " halt_reached"}, halt, 1);
  endtask

  task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
    dbg_sel = idx;
    #1;
    val = dbg_data;
  endtask

  typedef struct {
    string           name;
    logic [4:0][31:0] prog;
    int              len;
    int              dly;
    logic [4:0]      rsel;
    logic [31:0]     exp;
  } vec_t;

  function automatic vec_t mk(string n, logic [31:0] p0, logic [31:0] p1, logic [31:0] p2,
                              logic [31:0] p3, int len, int d, logic [4:0] r, logic [31:0] e);
    vec_t v;
    v.name = n; v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
    v.prog[4] = '0; v.len = len; v.dly = d; v.rsel = r; v.exp = e;
    return v;
  endfunction

  vec_t        vecs[$];
  vec_t        v;
  logic [31:0] val;
  int          r0, q0, f0, g0, n;

  initial begin
    rst_n   = 1'b0;
    ack     = 1'b0;
    rdata   = '0;
    dbg_sel = 5'd1;
    rdata16 = enc_i(12'd1, 5'd0, 3'b000, 5'd20);
    clear_mem();

    vecs.push_back(mk("add", enc_i(12'd5, 0, 0, 1), enc_i(12'hFFD, 0, 0, 2),
                      enc_r(7'h00, 2, 1, 3'b000, 3), 0, 3, 0, 3, 32'd2));
    vecs.push_back(mk("sub", enc_i(12'd5, 0, 0, 1), enc_i(12'd7, 0, 0, 2),
                      enc_r(7'h20, 2, 1, 3'b000, 3), 0, 3, 1, 3, 32'hFFFF_FFFE));
    vecs.push_back(mk("and", enc_i(12'h0F0, 0, 0, 1), enc_i(12'h03C, 0, 0, 2),
                      enc_r(7'h00, 2, 1, 3'b111, 3), 0, 3, 0, 3, 32'h30));
    vecs.push_back(mk("or", enc_i(12'h0F0, 0, 0, 1), enc_i(12'h03C, 0, 0, 2),
                      enc_r(7'h00, 2, 1, 3'b110, 3), 0, 3, 2, 3, 32'hFC));
    vecs.push_back(mk("xor", enc_i(12'h0F0, 0, 0, 1), enc_i(12'h03C, 0, 0, 2),
                      enc_r(7'h00, 2, 1, 3'b100, 3), 0, 3, 0, 3, 32'hCC));
    vecs.push_back(mk("sll_mask", enc_i(12'd3, 0, 0, 1), enc_i(12'd33, 0, 0, 2),
                      enc_r(7'h00, 2, 1, 3'b001, 3), 0, 3, 0, 3, 32'd6));
    vecs.push_back(mk("srai", enc_i(12'd1, 0, 0, 5), enc_i(12'd31, 0, 0, 6),
                      enc_r(7'h00, 6, 5, 3'b001, 5), enc_i(12'h402, 5, 3'b101, 4),
                      4, 0, 4, 32'hE000_0000));
    vecs.push_back(mk("x0_write", enc_i(12'd7, 0, 0, 0), 0, 0, 0, 1, 0, 0, 32'd0));
    vecs.push_back(mk("imm_edge", enc_i(12'h800, 0, 0, 1), enc_i(12'h7FF, 1, 0, 1),
                      0, 0, 2, 1, 1, 32'hFFFF_FFFF));

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_addr", addr, 0);
    check("rst_retire", retire, 0);
    check("rst_halt", halt, 0);
    read_reg(5'd1, val);
    check("rst_x1", val, 0);

    // First request two rising edges after release.
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("boot_edge1_req", req, 0);
    @(posedge clk); #1;
    check("boot_edge2_req", req, 1);
    check("boot_edge2_addr", addr, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      clear_mem();
      for (int k = 0; k < v.len; k++) mem[k] = v.prog[k];
      delay = v.dly;
      do_reset();
      r0 = retire_cnt;
      wait_halt(v.name);
      check({v.name, " retires"}, retire_cnt - r0, v.len);
      read_reg(v.rsel, val);
      check(v.name, val, v.exp);
    end

    // Retire spacing and fetch-address stability, zero-wait and 3-wait.
    for (int d = 0; d <= 3; d += 3) begin
      clear_mem();
      mem[0] = enc_i(12'd5, 0, 0, 1);
      mem[1] = enc_i(12'hFFD, 0, 0, 2);
      mem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
      delay = d;
      do_reset();
      q0 = retire_cyc.size(); f0 = fetch_addr.size(); g0 = addr_glitch;
      wait_halt("spacing");
      check("spacing_retires", retire_cyc.size() - q0, 3);
      if (retire_cyc.size() >= q0 + 3) begin
        check("spacing_1", retire_cyc[q0+1] - retire_cyc[q0], 4 + d);
        check("spacing_2", retire_cyc[q0+2] - retire_cyc[q0+1], 4 + d);
      end
      if (fetch_addr.size() >= f0 + 3) begin
        check("fetch_addr0", fetch_addr[f0], 32'h0);
        check("fetch_addr1", fetch_addr[f0+1], 32'h4);
        check("fetch_addr2", fetch_addr[f0+2], 32'h8);
      end
      check("addr_stable", addr_glitch - g0, 0);
      read_reg(5'd3, val);
      check("spacing_x3", val, 32'd2);
    end

    // beq taken and not taken at PC=0x10.
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      mem[0] = enc_i(12'd5, 0, 0, 1);
      mem[1] = enc_i(12'd6, 0, 0, 2);
      mem[2] = enc_i(12'd0, 0, 0, 3);
      mem[3] = enc_i(12'd0, 0, 0, 3);
      mem[4] = (t == 0) ? enc_b(13'd8, 1, 1) : enc_b(13'd8, 2, 1);
      if (t == 0) mem[5] = enc_i(12'd1, 0, 0, 9);
      delay = 0;
      do_reset();
      r0 = retire_cnt; f0 = fetch_addr.size();
      wait_halt("beq");
      check("beq_retires", retire_cnt - r0, 5);
      if (fetch_addr.size() >= f0 + 6)
        check("beq_next_addr", fetch_addr[f0+5], (t == 0) ? 32'h18 : 32'h14);
      else
        check("beq_fetch_count", fetch_addr.size() - f0, 6);
      read_reg(5'd8, val);
      check("beq_no_rd_write", val, 0);
      read_reg(5'd9, val);
      check("beq_skipped", val, 0);
    end

    // Illegal word halts, stays halted, and reset restarts at PC_RESET.
    clear_mem();
    mem[0] = 32'hFFFF_FFFF;
    do_reset();
    r0 = retire_cnt; f0 = fetch_addr.size();
    wait_halt("illegal");
    repeat (10) @(negedge clk);
    check("illegal_retires", retire_cnt - r0, 0);
    check("illegal_req_low", req, 0);
    check("illegal_halt_sticky", halt, 1);
    check("illegal_one_fetch", fetch_addr.size() - f0, 1);
    rst_n = 1'b0;
    #1;
    check("illegal_rst_halt", halt, 0);
    mem[0] = enc_i(12'd5, 0, 0, 1);
    @(negedge clk);
    f0 = fetch_addr.size();
    rst_n = 1'b1;
    wait_halt("restart");
    if (fetch_addr.size() > f0) check("restart_addr", fetch_addr[f0], 32'h0);
    read_reg(5'd1, val);
    check("restart_x1", val, 32'd5);

    // Reset in the middle of a program.
    clear_mem();
    mem[0] = enc_i(12'd5, 0, 0, 1);
    mem[1] = enc_i(12'hFFD, 0, 0, 2);
    mem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
    delay = 3;
    do_reset();
    r0 = retire_cnt; n = 0;
    while (retire_cnt < r0 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", retire_cnt - r0, 2);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_req", req, 0);
    check("mid_addr", addr, 0);
    check("mid_retire", retire, 0);
    read_reg(5'd1, val);
    check("mid_x1", val, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt("mid_restart");
    read_reg(5'd3, val);
    check("mid_restart_x3", val, 32'd2);

    // mul x6,x1,x1 with x1 = 0x10000.
    clear_mem();
    mem[0] = enc_i(12'd9, 0, 0, 6);
    mem[1] = enc_i(12'd1, 0, 0, 1);
    mem[2] = enc_i(12'd16, 0, 0, 2);
    mem[3] = enc_r(7'h00, 2, 1, 3'b001, 1);
    mem[4] = enc_r(7'h01, 1, 1, 3'b000, 6);
    delay = 0;
    do_reset();
    r0 = retire_cnt;
    wait_halt("mul");
    read_reg(5'd6, val);
`ifdef CPU_MUL_EN
    check("mul_retires", retire_cnt - r0, 5);
    check("mul_x6", val, 32'd0);
`else
    check("mul_retires", retire_cnt - r0, 4);
    check("mul_x6", val, 32'd9);
`endif

    // RV-E instance: rd=20 is illegal; index 20 reads zero.
    check("rve_halt", halt16, 1);
    check("rve_req", req16, 0);
    check("rve_addr", addr16, 0);
    check("rve_retires", retire16_cnt, 0);
    dbg_sel = 5'd20;
    #1;
    check("rve_dbg_oob", dbg_data16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
